// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants (opcodes, memory geometry) and the program memory controller mode enum
// Ports: none (package)
package cpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0111;
  localparam logic [3:0] OP_SLEEP = 4'b1000;
  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_SLEEP = 2'd2
  } mode_t;
endpackage

// File: rtl/prog_mem_16x4.sv
// prog_mem_16x4: single-port program memory, registered read, write enable, contents never reset
// Ports: clk; we/addr/wdata write side; rdata holds mem[addr] sampled on the previous edge (read-before-write)
module prog_mem_16x4 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: owns the CPU program memory, arbitrates CPU fetch vs host access and sequences LOAD/RUN/SLEEP
// Ports: clk, reset (async, active-low)
//   host_*  : host download/readback port (req held until gnt; rvalid/err one cycle after gnt)
//   cpu_*   : CPU fetch port, cpu_sleep status, cpu_hold/cpu_wakeup control
//   load_req/load_done : LOAD entry/exit pulses; wakeup_in : external wake
//   load_cnt : host writes accepted in this LOAD (saturates at 16); mode : LOAD=0 RUN=1 SLEEP=2
module prog_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  input  logic              load_req,
  input  logic              load_done,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_sleep,
  input  logic              wakeup_in,
  output logic              cpu_hold,
  output logic              cpu_wakeup,
  output logic [ADDR_W:0]   load_cnt,
  output logic [1:0]        mode
);
  mode_t state, nstate;
  logic run, last_cpu, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  assign run = state == MODE_RUN;
  // last_cpu=1 means the CPU won the previous RUN grant, so the host wins the next tie
  assign cpu_gnt  = run && cpu_req && !(host_req && last_cpu);
  assign host_gnt = host_req && !cpu_gnt;
  // host writes are acknowledged in RUN but never reach the array
  assign mem_we   = host_gnt && host_we && !run;
  assign mem_addr = cpu_gnt ? cpu_addr : host_addr;
  // read data is gated by rvalid so outputs read zero outside a valid beat
  assign host_rdata = host_rvalid ? mem_q : '0;
  assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
  prog_mem_16x4 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (host_wdata),
    .rdata (mem_q)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MODE_LOAD;
    else state <= nstate;
  end
  // load_req has top priority in every state
  always_comb begin
    nstate = load_req ? MODE_LOAD :
             state == MODE_LOAD  ? (load_done ? MODE_RUN : MODE_LOAD) :
             state == MODE_RUN   ? (cpu_sleep ? MODE_SLEEP : MODE_RUN) :
             state == MODE_SLEEP ? (wakeup_in ? MODE_RUN : MODE_SLEEP) : MODE_LOAD;
  end
  always_comb begin
    cpu_hold = state == MODE_LOAD;
    mode     = state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      cpu_wakeup  <= 1'b0;
      last_cpu    <= 1'b0;
      load_cnt    <= '0;
    end else begin
      host_rvalid <= host_gnt && !host_we;
      host_err    <= host_gnt && host_we && run;
      cpu_rvalid  <= cpu_gnt;
      cpu_wakeup  <= state == MODE_SLEEP && wakeup_in && !load_req;
      if (run && (cpu_gnt || host_gnt)) last_cpu <= cpu_gnt;
      load_cnt <= load_req ? '0 :
                  (state == MODE_LOAD && mem_we && !load_cnt[ADDR_W]) ? load_cnt + {{ADDR_W{1'b0}}, 1'b1} :
                  load_cnt;
    end
  end
endmodule

// File: doc/prog_mem_ctrl.md
# prog_mem_ctrl

Owner and arbiter of the CPU's 16 x 4-bit program memory. It shares one single-port array between the CPU fetch port and a host/assembler download port, and sequences the CPU through program load, run and sleep. It holds the CPU off the memory during download and arbitrates fetch vs. host readback while running. It also turns the CPU's SLEEP indication plus an external wakeup into a clean wake pulse.

## Interface
- `ADDR_W`, 4: address width; depth is 2^ADDR_W = 16.
- `DATA_W`, 4: nibble width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `host_req` in 1: host access request; held until granted.
- `host_we` in 1: 1 = write, 0 = read; qualified by `host_req`.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_gnt` out 1: one-cycle grant; the access is performed on this edge.
- `host_rvalid` out 1: read data valid, one cycle after a read grant.
- `host_rdata` out DATA_W: host read data.
- `host_err` out 1: one-cycle pulse, one cycle after a rejected write.
- `load_req` in 1: pulse; enter LOAD.
- `load_done` in 1: pulse; leave LOAD.
- `cpu_req` in 1: CPU fetch request; held until granted.
- `cpu_addr` in ADDR_W: fetch address (the CPU's PC).
- `cpu_gnt` out 1: one-cycle fetch grant.
- `cpu_rvalid` out 1: fetch data valid, one cycle after grant.
- `cpu_rdata` out DATA_W: fetched nibble.
- `cpu_sleep` in 1: high while the CPU sits in its SLEEP state (opcode 4'b1000).
- `wakeup_in` in 1: external wake request.
- `cpu_hold` out 1: holds the CPU in reset.
- `cpu_wakeup` out 1: one-cycle wake pulse to the CPU `wakeup` input.
- `load_cnt` out ADDR_W+1: number of host writes accepted in the current LOAD, saturating at 16.
- `mode` out 2: current state, encoded LOAD=0, RUN=1, SLEEP=2.

## Operation
- States are LOAD, RUN and SLEEP. Reset enters LOAD.
- **LOAD**
  - `cpu_hold`=1. `cpu_req` is ignored, with no grant.
  - The host has exclusive access, reads and writes. `host_gnt` is asserted in the same cycle as `host_req`.
  - Each granted write increments `load_cnt`, saturating at 16.
  - `load_done` moves to RUN. `load_cnt` clears on entry to LOAD.
- **RUN**
  - `cpu_hold`=0.
  - CPU fetches and host reads are arbitrated round-robin with a 1-bit last-grant pointer. The pointer favours the CPU after reset.
  - A lone requester is granted immediately. When both request, the one not granted last wins.
  - A host write is granted but does not modify memory; `host_err` pulses the next cycle and `host_rvalid` stays 0.
  - `load_req` moves to LOAD. `cpu_sleep`=1 moves to SLEEP.
- **SLEEP**
  - `cpu_hold`=0. The CPU is not granted.
  - The host has full read/write access. Writes patch memory and do not count in `load_cnt`.
  - `wakeup_in` moves to RUN and drives `cpu_wakeup` high for exactly the first RUN cycle.
  - `load_req` moves to LOAD.
- **Priority of simultaneous events**
  - `load_req` beats `cpu_sleep`, `wakeup_in` and `load_done`.
  - `load_done` and `load_req` together in LOAD: stay in LOAD, and `load_cnt` clears.
  - A request granted in the same cycle as a state change completes under the old state's rules.
- **Arithmetic:** `load_cnt` is 5 bits and saturates at 16. Address wrap is natural at 4 bits; addresses are not checked.

## Timing
- **Grants:** combinational from `*_req`, state and pointer. Memory writes on the grant edge. Read data is registered and valid in grant cycle + 1 (latency 1).
- **Back-to-back:** a requester may be granted in consecutive cycles.
- **Throughput:** one access per cycle. Under continuous contention each requester gets one access every 2 cycles.
- **State changes:** take effect the cycle after the causing input is sampled. `cpu_hold` changes in that same cycle.
- **Reset values**
  - `mode`=LOAD, `cpu_hold`=1, `load_cnt`=0.
  - All gnt/rvalid/err/wakeup outputs = 0.
  - `host_rdata` = 0, `cpu_rdata` = 0, pointer = CPU.
- **Memory contents are not reset.** A reset mid-LOAD keeps already-written nibbles.
- **Reset mid-access:** a pending rvalid is dropped.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (LOAD 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XNOR 0111, SLEEP 1000);
  - `ADDR_W`/`DATA_W` defaults;
  - the `mode` enum.
- Sub-module `prog_mem_16x4`: single-port array with registered read, write enable and no reset. The FSM, arbiter and counters stay in `prog_mem_ctrl`.

## Test plan
- **Download:** after reset, host writes 0001,0101,0001,0011,0010,0000,0011,0000,0100,0000,0101,0000,0111,0000,1000,0000 to addresses 0..15 → 16 grants, `load_cnt`=16. Then `load_done` → `mode`=RUN and `cpu_hold`=0 next cycle.
- **Fetch:** `cpu_req`, `cpu_addr`=4 → `cpu_gnt` the same cycle; next cycle `cpu_rvalid`=1, `cpu_rdata`=0010. A `cpu_req` during LOAD → no grant.
- **Contention:** `cpu_req` and a host read held together for 4 cycles → grants alternate CPU, host, CPU, host. Each rvalid follows its grant by 1 cycle.
- **Protection:** a host write of 1111 to address 0 in RUN → `host_gnt`, `host_err` the next cycle; a readback of address 0 returns 0001.
- **Sleep/wake:** `cpu_sleep`=1 → SLEEP. A host write of 0010 to address 14 succeeds. `wakeup_in` → RUN and a single-cycle `cpu_wakeup`. `wakeup_in` together with `load_req` → LOAD, no wake pulse.
- **Reset mid-LOAD:** after 5 writes, assert `reset` → `load_cnt`=0, `cpu_hold`=1, `mode`=LOAD; a readback of address 3 still returns the written value.
